// File: rtl/pcie_dma_desc_arb.sv
// PCIe DMA descriptor arbiter: per-channel descriptor FIFOs feeding one
// round-robin arbitrated output register, with completion tracking.
//
// Ports:
//   pcie_clk, pcie_rst           clock, async active-high reset
//   desc_wr_valid/ch/data/ready  host descriptor write into channel FIFO
//   dma_desc_valid/ready/data/id descriptor offered to the DMA engine
//   dma_done_valid/id            completion from the DMA engine
//   ch_busy                      channel has a descriptor offered/in flight
//   irq_pending, irq_clr         sticky completion flags, per-bit clear
//   err_ovf, err_done            sticky dropped-write / bad-completion flags
module pcie_dma_desc_arb #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DESC_W     = 160,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              pcie_clk,
    input  logic              pcie_rst,
    input  logic              desc_wr_valid,
    input  logic [CH_W-1:0]   desc_wr_ch,
    input  logic [DESC_W-1:0] desc_wr_data,
    output logic              desc_wr_ready,
    output logic              dma_desc_valid,
    input  logic              dma_desc_ready,
    output logic [DESC_W-1:0] dma_desc_data,
    output logic [CH_W-1:0]   dma_desc_id,
    input  logic              dma_done_valid,
    input  logic [CH_W-1:0]   dma_done_id,
    output logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] irq_pending,
    input  logic [NUM_CH-1:0] irq_clr,
    output logic              err_ovf,
    output logic              err_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DESC_W-1:0] mem_q  [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q [NUM_CH];
    logic [PTR_W-1:0]  wptr_d [NUM_CH];
    logic [PTR_W-1:0]  rptr_q [NUM_CH];
    logic [PTR_W-1:0]  rptr_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];

    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] irq_q, irq_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic              valid_q, valid_d;
    logic [DESC_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   id_q, id_d;
    logic              ovf_q, ovf_d;
    logic              derr_q, derr_d;

    logic [NUM_CH-1:0] wr_hit, done_hit, full, elig;
    logic [NUM_CH-1:0] push, pop, done_ok;
    logic              loadable, grant_found, grant_en;
    logic [CH_W-1:0]   grant_idx;

    // Channel decode; ids beyond NUM_CH hit nothing, so they read
    // as not-ready for writes and as bad completions.
    always_comb begin
        wr_hit   = '0;
        done_hit = '0;
        full     = '0;
        elig     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]   = desc_wr_ch == CH_W'(i);
            done_hit[i] = dma_done_id == CH_W'(i);
            full[i]     = cnt_q[i] == FULL_CNT;
            elig[i]     = (cnt_q[i] != '0) && !busy_q[i];
        end
    end

    // Full is taken from the registered count, so a same-cycle pop
    // does not open a slot for the write.
    assign desc_wr_ready = |(wr_hit & ~full);
    assign push          = {NUM_CH{desc_wr_valid}} & wr_hit & ~full;
    assign done_ok       = {NUM_CH{dma_done_valid}} & done_hit & busy_q;
    assign loadable      = !valid_q || dma_desc_ready;

    // Round-robin: probe last+1, last+2, ... (mod NUM_CH), first
    // eligible channel wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_found && elig[i] &&
                    (((int'(last_q) + k) % NUM_CH) == i)) begin
                    grant_found = 1'b1;
                    grant_idx   = CH_W'(i);
                end
            end
        end
    end

    assign grant_en = loadable && grant_found;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = grant_en && (grant_idx == CH_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wptr_d[i] = wptr_q[i] + PTR_W'(push[i]);
            rptr_d[i] = rptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]  = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
        busy_d  = (busy_q | pop) & ~done_ok;
        irq_d   = (irq_q & ~irq_clr) | done_ok;
        ovf_d   = ovf_q | (desc_wr_valid && !desc_wr_ready);
        derr_d  = derr_q | (dma_done_valid && (done_ok == '0));
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        if (grant_en) begin
            valid_d = 1'b1;
            data_d  = mem_q[grant_idx][rptr_q[grant_idx]];
            id_d    = grant_idx;
            last_d  = grant_idx;
        end else if (dma_desc_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            busy_q  <= '0;
            irq_q   <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            busy_q  <= busy_d;
            irq_q   <= irq_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
            derr_q  <= derr_d;
        end
    end

    // Storage needs no reset: the counts gate every read.
    always_ff @(posedge pcie_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i] && !pcie_rst) begin
                mem_q[i][wptr_q[i]] <= desc_wr_data;
            end
        end
    end

    assign dma_desc_valid = valid_q;
    assign dma_desc_data  = data_q;
    assign dma_desc_id    = id_q;
    assign ch_busy        = busy_q;
    assign irq_pending    = irq_q;
    assign err_ovf        = ovf_q;
    assign err_done       = derr_q;

endmodule

// File: tb/tb_pcie_dma_desc_arb.sv
// Testbench for pcie_dma_desc_arb: scenario tasks with a scoreboard
// queue of expected descriptors in the order they should be granted.
module tb_pcie_dma_desc_arb;
    localparam int NUM_CH     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int DESC_W     = 160;
    localparam int CH_W       = 2;

    logic              pcie_clk = 1'b0;
    logic              pcie_rst = 1'b1;
    logic              desc_wr_valid = 1'b0;
    logic [CH_W-1:0]   desc_wr_ch = '0;
    logic [DESC_W-1:0] desc_wr_data = '0;
    logic              desc_wr_ready;
    logic              dma_desc_valid;
    logic              dma_desc_ready = 1'b0;
    logic [DESC_W-1:0] dma_desc_data;
    logic [CH_W-1:0]   dma_desc_id;
    logic              dma_done_valid = 1'b0;
    logic [CH_W-1:0]   dma_done_id = '0;
    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH-1:0] irq_pending;
    logic [NUM_CH-1:0] irq_clr = '0;
    logic              err_ovf;
    logic              err_done;

    typedef struct packed {
        logic [CH_W-1:0]   id;
        logic [DESC_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    pcie_dma_desc_arb #(
        .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH),
        .DESC_W(DESC_W), .CH_W(CH_W)
    ) dut (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
        .desc_wr_valid(desc_wr_valid), .desc_wr_ch(desc_wr_ch),
        .desc_wr_data(desc_wr_data), .desc_wr_ready(desc_wr_ready),
        .dma_desc_valid(dma_desc_valid), .dma_desc_ready(dma_desc_ready),
        .dma_desc_data(dma_desc_data), .dma_desc_id(dma_desc_id),
        .dma_done_valid(dma_done_valid), .dma_done_id(dma_done_id),
        .ch_busy(ch_busy), .irq_pending(irq_pending), .irq_clr(irq_clr),
        .err_ovf(err_ovf), .err_done(err_done)
    );

    always #5 pcie_clk = ~pcie_clk;

    // Stimulus only: one write over one edge, optionally recorded.
    task automatic wr(input logic [CH_W-1:0] ch, input logic [DESC_W-1:0] d,
                      input bit rec);
        desc_wr_valid = 1'b1;
        desc_wr_ch    = ch;
        desc_wr_data  = d;
        if (rec) sb.push_back('{id: ch, data: d});
        @(posedge pcie_clk); #1;
        desc_wr_valid = 1'b0;
    endtask

    task automatic clr_irq();
        irq_clr = '1;
        @(posedge pcie_clk); #1;
        irq_clr = '0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (dma_desc_valid !== 1'b0 || dma_desc_data !== '0 || dma_desc_id !== '0) begin
            errors++;
            $display("FAIL reset_out valid=%b id=%0d data=%h want 0", dma_desc_valid, dma_desc_id, dma_desc_data);
        end
        checks++;
        if (ch_busy !== 4'b0 || irq_pending !== 4'b0 || err_ovf !== 1'b0 || err_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b irq=%b ovf=%b derr=%b want 0", ch_busy, irq_pending, err_ovf, err_done);
        end
        desc_wr_ch = 2'd1;
        #1;
        checks++;
        if (desc_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want 1", desc_wr_ready);
        end
        desc_wr_valid = 1'b1;
        desc_wr_data  = 160'h1234;
        @(posedge pcie_clk); #1;
        desc_wr_valid = 1'b0;
        pcie_rst = 1'b0;
        repeat (3) @(posedge pcie_clk);
        @(negedge pcie_clk);
        checks++;
        if (dma_desc_valid !== 1'b0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_ignored valid=%b ovf=%b want 0 0", dma_desc_valid, err_ovf);
        end
        @(posedge pcie_clk); #1;
    endtask

    task automatic test_single();
        wr(2'd2, 160'hA5, 1'b1);
        checks++;
        if (dma_desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early got=%b want 0", dma_desc_valid);
        end
        @(posedge pcie_clk); #1;
        checks++;
        if (dma_desc_valid !== 1'b1 || dma_desc_id !== 2'd2 || dma_desc_data !== 160'hA5) begin
            errors++;
            $display("FAIL single_offer valid=%b id=%0d data=%h want 1 2 a5", dma_desc_valid, dma_desc_id, dma_desc_data);
        end
        checks++;
        if (ch_busy !== 4'b0100) begin
            errors++;
            $display("FAIL single_busy got=%b want 0100", ch_busy);
        end
        dma_desc_ready = 1'b1;
        @(negedge pcie_clk);
        checks++;
        e = sb.pop_front();
        if (dma_desc_id !== e.id || dma_desc_data !== e.data) begin
            errors++;
            $display("FAIL single_sb id=%0d data=%h want %0d %h", dma_desc_id, dma_desc_data, e.id, e.data);
        end
        @(posedge pcie_clk); #1;
        dma_desc_ready = 1'b0;
        dma_done_valid = 1'b1;
        dma_done_id    = 2'd2;
        checks++;
        if (dma_desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop got=%b want 0", dma_desc_valid);
        end
        @(posedge pcie_clk); #1;
        dma_done_valid = 1'b0;
        checks++;
        if (ch_busy !== 4'b0 || irq_pending !== 4'b0100 || err_done !== 1'b0) begin
            errors++;
            $display("FAIL single_done busy=%b irq=%b derr=%b want 0000 0100 0", ch_busy, irq_pending, err_done);
        end
        clr_irq();
        checks++;
        if (irq_pending !== 4'b0) begin
            errors++;
            $display("FAIL single_irqclr got=%b want 0000", irq_pending);
        end
    endtask

    task automatic test_round_robin();
        int got;
        bit acc;
        logic [CH_W-1:0] aid;
        got = 0;
        aid = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++)
                wr(CH_W'(c), DESC_W'(32'h100 + r * 16 + c), 1'b1);
        dma_desc_ready = 1'b1;
        for (int n = 0; n < 60 && got < 8; n++) begin
            @(negedge pcie_clk);
            acc = dma_desc_valid && dma_desc_ready;
            if (acc) begin
                checks++;
                e = sb.pop_front();
                if (dma_desc_id !== e.id || dma_desc_data !== e.data) begin
                    errors++;
                    $display("FAIL rr_order id=%0d data=%h want %0d %h", dma_desc_id, dma_desc_data, e.id, e.data);
                end
                aid = dma_desc_id;
                got++;
            end
            @(posedge pcie_clk); #1;
            dma_done_valid = acc;
            dma_done_id    = aid;
        end
        @(posedge pcie_clk); #1;
        dma_done_valid = 1'b0;
        dma_desc_ready = 1'b0;
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL rr_count got=%0d want 8", got);
        end
        checks++;
        if (ch_busy !== 4'b0 || irq_pending !== 4'b1111) begin
            errors++;
            $display("FAIL rr_final busy=%b irq=%b want 0000 1111", ch_busy, irq_pending);
        end
        clr_irq();
    endtask

    task automatic test_back_pressure();
        int got;
        bit acc;
        logic [CH_W-1:0] aid;
        got = 0;
        aid = '0;
        wr(2'd1, 160'hB1, 1'b1);
        wr(2'd1, 160'hB2, 1'b1);
        for (int n = 0; n < 5; n++) begin
            @(negedge pcie_clk);
            checks++;
            if (dma_desc_valid !== 1'b1 || dma_desc_id !== 2'd1 || dma_desc_data !== 160'hB1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%b id=%0d data=%h want 1 1 b1", n, dma_desc_valid, dma_desc_id, dma_desc_data);
            end
        end
        @(posedge pcie_clk); #1;
        dma_desc_ready = 1'b1;
        for (int n = 0; n < 30 && got < 2; n++) begin
            @(negedge pcie_clk);
            acc = dma_desc_valid && dma_desc_ready;
            if (acc) begin
                checks++;
                e = sb.pop_front();
                if (dma_desc_id !== e.id || dma_desc_data !== e.data) begin
                    errors++;
                    $display("FAIL bp_sb id=%0d data=%h want %0d %h", dma_desc_id, dma_desc_data, e.id, e.data);
                end
                aid = dma_desc_id;
                got++;
            end
            @(posedge pcie_clk); #1;
            dma_done_valid = acc;
            dma_done_id    = aid;
        end
        @(posedge pcie_clk); #1;
        dma_done_valid = 1'b0;
        repeat (3) @(posedge pcie_clk);
        @(negedge pcie_clk);
        checks++;
        if (got != 2 || dma_desc_valid !== 1'b0 || ch_busy !== 4'b0) begin
            errors++;
            $display("FAIL bp_drain got=%0d valid=%b busy=%b want 2 0 0000", got, dma_desc_valid, ch_busy);
        end
        @(posedge pcie_clk); #1;
        dma_desc_ready = 1'b0;
        clr_irq();
    endtask

    task automatic test_back_to_back();
        wr(2'd2, 160'hC2, 1'b1);
        wr(2'd3, 160'hC3, 1'b1);
        dma_desc_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge pcie_clk);
            checks++;
            e = sb.pop_front();
            if (dma_desc_valid !== 1'b1 || dma_desc_id !== e.id || dma_desc_data !== e.data) begin
                errors++;
                $display("FAIL b2b beat=%0d valid=%b id=%0d data=%h want 1 %0d %h", n, dma_desc_valid, dma_desc_id, dma_desc_data, e.id, e.data);
            end
            @(posedge pcie_clk); #1;
        end
        dma_desc_ready = 1'b0;
        for (int c = 2; c < 4; c++) begin
            dma_done_valid = 1'b1;
            dma_done_id    = CH_W'(c);
            @(posedge pcie_clk); #1;
        end
        dma_done_valid = 1'b0;
        checks++;
        if (ch_busy !== 4'b0 || irq_pending !== 4'b1100 || dma_desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done busy=%b irq=%b valid=%b want 0000 1100 0", ch_busy, irq_pending, dma_desc_valid);
        end
        clr_irq();
    endtask

    task automatic test_overflow();
        int got;
        bit acc;
        logic [CH_W-1:0] aid;
        got = 0;
        aid = '0;
        wr(2'd1, 160'hD1, 1'b1);
        for (int n = 0; n < 4; n++) begin
            desc_wr_ch = 2'd0;
            #1;
            checks++;
            if (desc_wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL ovf_ready wr=%0d got=%b want 1", n, desc_wr_ready);
            end
            wr(2'd0, DESC_W'(32'hE0 + n), 1'b1);
        end
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got=%b want 0", err_ovf);
        end
        desc_wr_valid = 1'b1;
        desc_wr_ch    = 2'd0;
        desc_wr_data  = 160'hEF;
        @(negedge pcie_clk);
        checks++;
        if (desc_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full got=%b want 0", desc_wr_ready);
        end
        @(posedge pcie_clk); #1;
        desc_wr_valid = 1'b0;
        checks++;
        if (err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got=%b want 1", err_ovf);
        end
        dma_desc_ready = 1'b1;
        for (int n = 0; n < 60 && got < 5; n++) begin
            @(negedge pcie_clk);
            acc = dma_desc_valid && dma_desc_ready;
            if (acc) begin
                checks++;
                e = sb.pop_front();
                if (dma_desc_id !== e.id || dma_desc_data !== e.data) begin
                    errors++;
                    $display("FAIL ovf_contents id=%0d data=%h want %0d %h", dma_desc_id, dma_desc_data, e.id, e.data);
                end
                aid = dma_desc_id;
                got++;
            end
            @(posedge pcie_clk); #1;
            dma_done_valid = acc;
            dma_done_id    = aid;
        end
        @(posedge pcie_clk); #1;
        dma_done_valid = 1'b0;
        @(negedge pcie_clk);
        checks++;
        if (got != 5 || dma_desc_valid !== 1'b0 || err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain got=%0d valid=%b ovf=%b want 5 0 1", got, dma_desc_valid, err_ovf);
        end
        @(posedge pcie_clk); #1;
        dma_desc_ready = 1'b0;
        clr_irq();
    endtask

    task automatic test_errors();
        dma_done_valid = 1'b1;
        dma_done_id    = 2'd3;
        @(posedge pcie_clk); #1;
        dma_done_valid = 1'b0;
        checks++;
        if (err_done !== 1'b1 || ch_busy !== 4'b0 || irq_pending !== 4'b0) begin
            errors++;
            $display("FAIL err_done derr=%b busy=%b irq=%b want 1 0000 0000", err_done, ch_busy, irq_pending);
        end
        wr(2'd1, 160'hF1, 1'b1);
        @(posedge pcie_clk); #1;
        dma_desc_ready = 1'b1;
        @(negedge pcie_clk);
        checks++;
        e = sb.pop_front();
        if (dma_desc_valid !== 1'b1 || dma_desc_id !== e.id || dma_desc_data !== e.data) begin
            errors++;
            $display("FAIL err_offer valid=%b id=%0d data=%h want 1 %0d %h", dma_desc_valid, dma_desc_id, dma_desc_data, e.id, e.data);
        end
        @(posedge pcie_clk); #1;
        dma_desc_ready = 1'b0;
        dma_done_valid = 1'b1;
        dma_done_id    = 2'd1;
        irq_clr        = 4'b0010;
        @(posedge pcie_clk); #1;
        dma_done_valid = 1'b0;
        irq_clr        = '0;
        checks++;
        if (irq_pending !== 4'b0010 || ch_busy !== 4'b0 || err_done !== 1'b1) begin
            errors++;
            $display("FAIL err_race irq=%b busy=%b derr=%b want 0010 0000 1", irq_pending, ch_busy, err_done);
        end
    endtask

    task automatic test_reset_mid();
        int got;
        got = 0;
        wr(2'd2, 160'h52, 1'b1);
        for (int n = 0; n < 3; n++) wr(2'd0, DESC_W'(32'h60 + n), 1'b1);
        #2;
        pcie_rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (dma_desc_valid !== 1'b0 || dma_desc_data !== '0 || dma_desc_id !== '0 ||
            ch_busy !== 4'b0 || irq_pending !== 4'b0 || err_ovf !== 1'b0 || err_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid valid=%b id=%0d busy=%b irq=%b ovf=%b derr=%b want all 0", dma_desc_valid, dma_desc_id, ch_busy, irq_pending, err_ovf, err_done);
        end
        @(posedge pcie_clk); #1;
        pcie_rst = 1'b0;
        dma_desc_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge pcie_clk);
            checks++;
            if (dma_desc_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale cyc=%0d got=%b want 0", n, dma_desc_valid);
            end
        end
        @(posedge pcie_clk); #1;
        wr(2'd3, 160'h77, 1'b1);
        for (int n = 0; n < 10 && got < 1; n++) begin
            @(negedge pcie_clk);
            if (dma_desc_valid) begin
                checks++;
                e = sb.pop_front();
                if (dma_desc_id !== e.id || dma_desc_data !== e.data) begin
                    errors++;
                    $display("FAIL rst_new id=%0d data=%h want %0d %h", dma_desc_id, dma_desc_data, e.id, e.data);
                end
                got++;
            end
            @(posedge pcie_clk); #1;
        end
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL rst_new_timeout got=%0d want 1", got);
        end
        dma_desc_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_back_to_back();
        test_overflow();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_dma_desc_arb.md
PCIE_DMA_DESC_ARB -- requirements
Module: pcie_dma_desc_arb

Interface
REQ-001 Parameters SHALL be: NUM_CH, 4, channel count (1..8); FIFO_DEPTH, 4, descriptors per channel FIFO (power of 2, 2..16); DESC_W, 160, opaque descriptor width; CH_W, clog2(NUM_CH) min 1, channel id width.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- pcie_clk  in  1  sole clock, all logic on rising edge.
- pcie_rst  in  1  async active-high reset.
- desc_wr_valid  in  1  host descriptor write strobe.
- desc_wr_ch  in  CH_W  target channel.
- desc_wr_data  in  DESC_W  descriptor payload.
- desc_wr_ready  out  1  target channel FIFO not full (combinational from registered count and desc_wr_ch).
- dma_desc_valid  out  1  descriptor offered to DMA engine.
- dma_desc_ready  in  1  DMA engine accepts.
- dma_desc_data  out  DESC_W  offered descriptor.
- dma_desc_id  out  CH_W  channel of offered descriptor.
- dma_done_valid  in  1  completion strobe.
- dma_done_id  in  CH_W  completing channel.
- ch_busy  out  NUM_CH  per-channel descriptor outstanding.
- irq_pending  out  NUM_CH  sticky completion flag.
- irq_clr  in  NUM_CH  per-bit clear of irq_pending.
- err_ovf  out  1  sticky: write dropped (FIFO full or desc_wr_ch >= NUM_CH).
- err_done  out  1  sticky: completion for non-busy or out-of-range channel.

Function
REQ-004 Each channel SHALL own a FIFO_DEPTH-entry FIFO with wrapping read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
REQ-005 A write SHALL be stored when desc_wr_valid & desc_wr_ready; desc_wr_ready SHALL be 0 for full or out-of-range channel, even if that FIFO pops the same cycle.
REQ-006 desc_wr_valid with desc_wr_ready=0 SHALL drop the data, leave all FIFOs unchanged, and set err_ovf.
REQ-007 A channel SHALL be eligible when its FIFO count > 0 and its registered ch_busy bit is 0.
REQ-008 Output register SHALL be loadable when dma_desc_valid=0, or dma_desc_valid & dma_desc_ready in the same cycle.
REQ-009 When loadable and at least one channel is eligible, the arbiter SHALL grant round-robin: search starts at (last_grant+1) mod NUM_CH, first eligible wins; last_grant resets to NUM_CH-1 so channel 0 wins first.
REQ-010 On grant the granted FIFO SHALL pop into dma_desc_data/dma_desc_id, dma_desc_valid SHALL be 1 next cycle, ch_busy[grant] SHALL set, last_grant SHALL update.
REQ-011 While dma_desc_valid=1 and dma_desc_ready=0, dma_desc_data and dma_desc_id SHALL hold stable.
REQ-012 Accept with no eligible channel SHALL clear dma_desc_valid next cycle; accept with an eligible channel SHALL give back-to-back valid (one descriptor per cycle).
REQ-013 Latency: write accepted at edge E into an empty FIFO of an idle channel with output loadable SHALL give dma_desc_valid=1 after edge E+1.
REQ-014 At most one descriptor per channel SHALL be outstanding (offered or in flight) at any time.
REQ-015 dma_done_valid for in-range busy channel SHALL clear ch_busy[id] and set irq_pending[id] at the next edge; that channel becomes eligible one cycle later (eligibility uses registered ch_busy).
REQ-016 dma_done_valid for non-busy or out-of-range id SHALL change no busy/irq state and SHALL set err_done.
REQ-017 irq_clr[i] SHALL clear irq_pending[i]; simultaneous set and clear of the same bit SHALL leave it set.
REQ-018 err_ovf and err_done SHALL only be cleared by reset.
REQ-019 Simultaneous write and pop on the same FIFO SHALL both take effect; count unchanged.

Reset
REQ-020 pcie_rst asserted SHALL immediately force: all FIFO counts/pointers 0, dma_desc_valid 0, dma_desc_data 0, dma_desc_id 0, ch_busy 0, irq_pending 0, err_ovf 0, err_done 0, last_grant NUM_CH-1.
REQ-021 Reset mid-transfer SHALL discard queued and offered descriptors; no output change until first edge after pcie_rst deasserts.
REQ-022 desc_wr_ready SHALL read 1 for in-range channels while in reset; writes during reset SHALL be ignored.

Verification
REQ-023 Single: write ch2 data 0xA5 at edge E, ready=1 -> dma_desc_valid=1, id=2, data=0xA5 after E+1; ch_busy=0b0100; done id=2 -> ch_busy=0, irq_pending=0b0100.
REQ-024 Round-robin: two descriptors each in ch0..ch3, ready=1, completion each cycle after accept -> grant order 0,1,2,3,0,1,2,3.
REQ-025 Back-pressure: ready=0 for 5 cycles with ch1 queued -> data/id stable 5 cycles, ch1 FIFO count drops by exactly 1.
REQ-026 Overflow: 5 writes to ch0 (FIFO_DEPTH=4), no grants -> desc_wr_ready=0 on 5th, err_ovf=1, count=4, FIFO contents = first 4 in order.
REQ-027 Errors/races: done id=3 with ch3 idle -> err_done=1, state unchanged; irq_clr[1] with concurrent done id=1 -> irq_pending[1]=1.
REQ-028 Reset mid-operation: pcie_rst pulse with valid=1 and 3 entries queued -> all outputs 0 immediately; no descriptor after release until new write.
